iir_stream_checker: RTL and testbench
=====================================

# iir_stream_checker

Self-checking output sink for the first-order IIR filter testbench. It watches the same input stream the stimulus generator drives into the filter and computes the expected output with a bit-accurate golden model. Expected samples are queued in an internal FIFO and compared against each valid output from the filter. It reports a mismatch count, sticky protocol-violation flags, and an end-of-simulation pass/fail verdict, so regressions need no external file diffing.

## Interface
- DEPTH, 8: expected-sample FIFO depth (power of two, ≥2); bounds tolerated DUT latency in samples.
- TOL, 0: allowed absolute difference |DIN − expected| in LSBs before a sample counts as a mismatch.
- TIMEOUT, 64: cycles allowed after END_SIM for outstanding samples to drain.
- CLK  in  1  clock; all state updates on rising edge.
- RST_n  in  1  asynchronous, active-low reset.
- DUT_VIN  in  1  input sample valid, as presented to the filter.
- DUT_DIN  in  12  input sample x[n], signed Q1.11.
- b0, b1, a1  in  12 each  filter coefficients, signed Q1.11; static while DUT_VIN activity is in progress.
- VIN  in  1  filter output valid.
- DIN  in  12  filter output y[n], signed Q1.11.
- END_SIM  in  1  stimulus exhausted (level); sampled each cycle.
- ERR  out  4  mismatch count, saturating at 15.
- NCHK  out  16  number of comparisons performed, wrapping.
- OVF  out  1  sticky: push attempted while FIFO full.
- UNF  out  1  sticky: VIN while FIFO empty.
- DONE  out  1  checking finished (held until reset).
- PASS  out  1  valid only when DONE=1.

## Operation
- Golden model, combinational on the DUT_VIN cycle: y = T(b0·x[n]) + T(b1·x[n−1]) − T(a1·y[n−1]).
  - T() takes the 24-bit signed product and keeps bits [22:11], which truncates toward −∞.
  - The sum is formed in 14 bits and saturated to [0x800, 0x7FF].
- History registers x[n−1] and y[n−1] reset to 0. They update only on DUT_VIN, and always update, including when the push is dropped.
- Push: on DUT_VIN, the expected y is written to the FIFO tail.
  - If full and not popping in the same cycle: OVF←1, the sample is dropped, and the count is unchanged.
- Pop/compare: on VIN with FIFO non-empty:
  - Pop the head and compare it against DIN.
  - NCHK increments.
  - If |DIN − head| > TOL (13-bit signed difference), ERR increments, saturating at 15.
- VIN with FIFO empty:
  - UNF←1; no compare, no NCHK change.
  - A same-cycle push still occurs; an entry pushed in that cycle is never compared against that cycle's DIN.
- Simultaneous push and pop on a full FIFO is legal: the count stays DEPTH and no OVF.
- Pointers: log2(DEPTH) bits plus one wrap bit. Full/empty are decoded from pointer equality and the wrap bit.
- FSM:
  - RUN → DRAIN when END_SIM=1.
  - DRAIN: push/pop continue; a timeout counter counts up from 0.
  - DRAIN → DONE when the FIFO is empty, or when the counter reaches TIMEOUT−1 (forced).
  - DONE: terminal. Further VIN/DUT_VIN are ignored; all counters and flags freeze.
- PASS = (ERR==0) & ~OVF & ~UNF & (FIFO empty at DONE entry) & (NCHK≠0). It is registered on DONE entry.

## Timing
- Reset values: ERR=0, NCHK=0, OVF=0, UNF=0, DONE=0, PASS=0, FIFO empty, state RUN.
- Asserting RST_n mid-operation clears everything immediately, asynchronously. No pending comparison survives.
- An expected sample pushed at edge k can be compared at edge k+1 at the earliest. Minimum supported DUT latency is 1 cycle.
- ERR, NCHK, OVF and UNF reflect an event one cycle after the edge where it was sampled (registered outputs).
- DONE rises 1 cycle after the DRAIN exit condition holds. PASS is valid in the same cycle as DONE.
- END_SIM deasserting during DRAIN does not return the FSM to RUN.

## Test plan
- b0=0x400, b1=0, a1=0; x=0x200 then 0x7FF; filter model with latency 2 → expected 0x100, 0x3FF. Required: ERR=0, NCHK=2, then END_SIM → DONE=1, PASS=1.
- Same setup with the DUT output corrupted to 0x101 on one sample. TOL=0 → ERR=1, PASS=0. TOL=1 → ERR=0, PASS=1.
- b0=0x7FF, b1=0x7FF, a1=0x800, with x=0x7FF held for several samples. Required: golden saturates to 0x7FF and matches a saturating DUT.
- 20 mismatching samples → ERR sticks at 15, NCHK=20.
- DEPTH=8 with 9 pushes and no VIN → OVF=1, PASS=0. Separately, VIN with an empty FIFO → UNF=1.
- END_SIM with 3 samples outstanding and VIN never returning → DONE exactly TIMEOUT cycles after DRAIN entry, PASS=0. Also assert RST_n during DRAIN → all outputs return to 0.

Source files
------------

// File: rtl/iir_stream_checker.sv
// Self-checking sink for a first-order IIR filter: recomputes each expected output
// from the filter's input stream, queues it, and compares against the filter's output.
module iir_stream_checker #(
    parameter int DEPTH   = 8,
    parameter int TOL     = 0,
    parameter int TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        DUT_VIN,
    input  logic [11:0] DUT_DIN,
    input  logic [11:0] b0,
    input  logic [11:0] b1,
    input  logic [11:0] a1,
    input  logic        VIN,
    input  logic [11:0] DIN,
    input  logic        END_SIM,
    output logic [3:0]  ERR,
    output logic [15:0] NCHK,
    output logic        OVF,
    output logic        UNF,
    output logic        DONE,
    output logic        PASS,
    output logic [1:0]  dbg_state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [12:0]   TOL_W  = 13'(TOL);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        state_q;
    logic [TW-1:0] tmr_q;
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [11:0]   x1_q, y1_q;
    logic [3:0]    err_q, err_d;
    logic [15:0]   nchk_q, nchk_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic          done_q, pass_q;
    logic [11:0]   mem_q [DEPTH];

    logic          active, empty, empty_d, full, push, pop, mismatch;
    logic [11:0]   head, y_exp, t0, t1, t2;
    logic [12:0]   diff, abs_diff;
    logic [13:0]   sum14;

    // Q1.11 product truncated toward -inf: low 24 bits of the product, bits [22:11].
    function automatic logic [11:0] mul_t(input logic [11:0] a, input logic [11:0] b);
        logic [23:0] ea, eb;
        ea = {{12{a[11]}}, a};
        eb = {{12{b[11]}}, b};
        return 12'((ea * eb) >> 11);
    endfunction

    always_comb begin
        t0    = mul_t(b0, DUT_DIN);
        t1    = mul_t(b1, x1_q);
        t2    = mul_t(a1, y1_q);
        sum14 = {{2{t0[11]}}, t0} + {{2{t1[11]}}, t1} - {{2{t2[11]}}, t2};
        y_exp = sum14[11:0];
        if (!sum14[13] && sum14[12:11] != 2'b00) begin
            y_exp = 12'h7FF;
        end else if (sum14[13] && sum14[12:11] != 2'b11) begin
            y_exp = 12'h800;
        end
    end

    always_comb begin
        active   = (state_q != S_DONE);
        empty    = (wr_q == rd_q);
        full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop      = active && VIN && !empty;
        push     = active && DUT_VIN && (!full || pop);
        head     = mem_q[rd_q[AW-1:0]];
        diff     = {DIN[11], DIN} - {head[11], head};
        abs_diff = diff[12] ? (13'd0 - diff) : diff;
        mismatch = pop && (abs_diff > TOL_W);

        err_d  = err_q;
        if (mismatch && err_q != 4'hF) begin
            err_d = err_q + 4'd1;
        end
        nchk_d  = pop ? nchk_q + 16'd1 : nchk_q;
        ovf_d   = ovf_q | (active && DUT_VIN && full && !pop);
        unf_d   = unf_q | (active && VIN && empty);
        wr_d    = push ? wr_q + (AW+1)'(1) : wr_q;
        rd_d    = pop ? rd_q + (AW+1)'(1) : rd_q;
        empty_d = (wr_d == rd_d);
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= y_exp;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_RUN;
            tmr_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            err_q   <= '0;
            nchk_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            err_q  <= err_d;
            nchk_q <= nchk_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            // History advances on every input sample, even when the push is dropped.
            if (active && DUT_VIN) begin
                x1_q <= DUT_DIN;
                y1_q <= y_exp;
            end
            case (state_q)
                S_RUN: begin
                    if (END_SIM) begin
                        state_q <= S_DRAIN;
                        tmr_q   <= '0;
                    end
                end
                S_DRAIN: begin
                    if (empty || tmr_q == T_LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == 4'd0) && !ovf_d && !unf_d && empty_d
                                   && (nchk_d != 16'd0);
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                default: state_q <= S_DONE;
            endcase
        end
    end

    assign ERR         = err_q;
    assign NCHK        = nchk_q;
    assign OVF         = ovf_q;
    assign UNF         = unf_q;
    assign DONE        = done_q;
    assign PASS        = pass_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_iir_stream_checker.sv
// Directed bench for iir_stream_checker: an emulated latency-2 filter replays hand-computed outputs.
module tb_iir_stream_checker;

    localparam int TIMEOUT = 64;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        DUT_VIN = 1'b0;
    logic [11:0] DUT_DIN = '0;
    logic [11:0] b0 = '0, b1 = '0, a1 = '0;
    logic        VIN = 1'b0;
    logic [11:0] DIN = '0;
    logic        END_SIM = 1'b0;

    logic [3:0]  err0, err1;
    logic [15:0] nchk0, nchk1;
    logic        ovf0, ovf1, unf0, unf1, done0, done1, pass0, pass1;
    logic [1:0]  st0, st1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] x_q[$];
    logic [11:0] exp_q[$];

    iir_stream_checker #(.DEPTH(8), .TOL(0), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST_n(RST_n), .DUT_VIN(DUT_VIN), .DUT_DIN(DUT_DIN),
        .b0(b0), .b1(b1), .a1(a1), .VIN(VIN), .DIN(DIN), .END_SIM(END_SIM),
        .ERR(err0), .NCHK(nchk0), .OVF(ovf0), .UNF(unf0), .DONE(done0), .PASS(pass0),
        .dbg_state_o(st0)
    );

    iir_stream_checker #(.DEPTH(8), .TOL(1), .TIMEOUT(TIMEOUT)) dut_tol1 (
        .CLK(CLK), .RST_n(RST_n), .DUT_VIN(DUT_VIN), .DUT_DIN(DUT_DIN),
        .b0(b0), .b1(b1), .a1(a1), .VIN(VIN), .DIN(DIN), .END_SIM(END_SIM),
        .ERR(err1), .NCHK(nchk1), .OVF(ovf1), .UNF(unf1), .DONE(done1), .PASS(pass1),
        .dbg_state_o(st1)
    );

    // Clock
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic idle_inputs();
        DUT_VIN = 1'b0;
        DUT_DIN = '0;
        VIN     = 1'b0;
        DIN     = '0;
        END_SIM = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST_n = 1'b0;
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);
    endtask

    task automatic set_coef(input logic [11:0] c0, input logic [11:0] c1, input logic [11:0] c2);
        b0 = c0;
        b1 = c1;
        a1 = c2;
    endtask

    task automatic add_vec(input logic [11:0] x, input logic [11:0] y);
        x_q.push_back(x);
        exp_q.push_back(y);
    endtask

    // Emulated filter with 2-cycle latency; sample cidx is replaced by cval.
    task automatic run_stream(input int cidx, input logic [11:0] cval);
        int n;
        logic [11:0] y;
        n = x_q.size();
        for (int c = 0; c < n + 2; c++) begin
            DUT_VIN = (c < n);
            DUT_DIN = (c < n) ? x_q.pop_front() : 12'h000;
            VIN     = (c >= 2);
            if (c >= 2) begin
                y   = exp_q.pop_front();
                DIN = (c - 2 == cidx) ? cval : y;
            end else begin
                DIN = '0;
            end
            @(negedge CLK);
        end
        idle_inputs();
    endtask

    task automatic end_and_wait(input int max_cyc, output int cyc);
        END_SIM = 1'b1;
        cyc = 0;
        while (!done0 && cyc < max_cyc) begin
            @(negedge CLK);
            cyc++;
        end
        END_SIM = 1'b0;
        check("done_reached", done0, 1);
    endtask

    task automatic push_n(input int n, input logic [11:0] x);
        for (int i = 0; i < n; i++) begin
            DUT_VIN = 1'b1;
            DUT_DIN = x;
            @(negedge CLK);
        end
        DUT_VIN = 1'b0;
    endtask

    int cyc;

    initial begin
        do_reset();
        check("rst_err", err0, 0);
        check("rst_nchk", nchk0, 0);
        check("rst_ovf", ovf0, 0);
        check("rst_unf", unf0, 0);
        check("rst_done", done0, 0);
        check("rst_pass", pass0, 0);
        check("rst_state", st0, 0);

        // Basic gain 0.5 stream
        set_coef(12'h400, 12'h000, 12'h000);
        add_vec(12'h200, 12'h100);
        add_vec(12'h7FF, 12'h3FF);
        run_stream(-1, 12'h000);
        check("basic_err", err0, 0);
        check("basic_nchk", nchk0, 2);
        end_and_wait(10, cyc);
        check("basic_pass", pass0, 1);
        DUT_VIN = 1'b1;
        VIN = 1'b1;
        DIN = 12'h555;
        repeat (3) @(negedge CLK);
        idle_inputs();
        check("frozen_nchk", nchk0, 2);
        check("frozen_unf", unf0, 0);
        check("frozen_done", done0, 1);

        // One corrupted sample: off by one LSB
        do_reset();
        add_vec(12'h200, 12'h100);
        add_vec(12'h7FF, 12'h3FF);
        run_stream(0, 12'h101);
        check("corrupt_err_tol0", err0, 1);
        check("corrupt_err_tol1", err1, 0);
        check("corrupt_nchk_tol1", nchk1, 2);
        end_and_wait(10, cyc);
        check("corrupt_pass_tol0", pass0, 0);
        check("corrupt_pass_tol1", pass1, 1);
        check("corrupt_done_tol1", done1, 1);

        // Positive saturation with feedback a1 = -1
        do_reset();
        set_coef(12'h7FF, 12'h7FF, 12'h800);
        add_vec(12'h7FF, 12'h7FE);
        add_vec(12'h7FF, 12'h7FF);
        add_vec(12'h7FF, 12'h7FF);
        add_vec(12'h7FF, 12'h7FF);
        run_stream(-1, 12'h000);
        check("sat_err", err0, 0);
        check("sat_nchk", nchk0, 4);

        // History paths and truncation toward -inf
        do_reset();
        set_coef(12'h400, 12'h400, 12'h400);
        add_vec(12'h200, 12'h100);
        add_vec(12'h200, 12'h180);
        add_vec(12'h000, 12'h040);
        add_vec(12'hFFF, 12'hFDF);
        run_stream(-1, 12'h000);
        check("hist_err", err0, 0);
        check("hist_nchk", nchk0, 4);
        end_and_wait(10, cyc);
        check("hist_pass", pass0, 1);

        // 20 mismatches saturate ERR
        do_reset();
        set_coef(12'h000, 12'h000, 12'h000);
        for (int i = 0; i < 20; i++) add_vec(12'h123, 12'h005);
        run_stream(-1, 12'h000);
        check("errsat_err", err0, 15);
        check("errsat_nchk", nchk0, 20);

        // Overflow: 9 pushes into depth 8, then drain 8
        do_reset();
        push_n(9, 12'h100);
        check("ovf_flag", ovf0, 1);
        check("ovf_nchk", nchk0, 0);
        VIN = 1'b1;
        DIN = 12'h000;
        repeat (8) @(negedge CLK);
        VIN = 1'b0;
        check("ovf_drain_nchk", nchk0, 8);
        check("ovf_drain_err", err0, 0);
        check("ovf_unf", unf0, 0);
        end_and_wait(10, cyc);
        check("ovf_pass", pass0, 0);

        // Underflow, with a same-cycle push that must not be compared then
        do_reset();
        VIN = 1'b1;
        DUT_VIN = 1'b1;
        DIN = 12'h7FF;
        @(negedge CLK);
        DUT_VIN = 1'b0;
        check("unf_flag", unf0, 1);
        check("unf_nchk", nchk0, 0);
        DIN = 12'h000;
        @(negedge CLK);
        VIN = 1'b0;
        check("unf_next_nchk", nchk0, 1);
        check("unf_next_err", err0, 0);

        // Drain timeout with 3 outstanding samples
        do_reset();
        set_coef(12'h400, 12'h000, 12'h000);
        push_n(3, 12'h200);
        end_and_wait(TIMEOUT + 10, cyc);
        check("timeout_cycles", cyc, TIMEOUT + 1);
        check("timeout_pass", pass0, 0);
        check("timeout_nchk", nchk0, 0);

        // Asynchronous reset during DRAIN
        do_reset();
        push_n(3, 12'h200);
        VIN = 1'b1;
        DIN = 12'h000;
        @(negedge CLK);
        VIN = 1'b0;
        END_SIM = 1'b1;
        repeat (5) @(negedge CLK);
        check("drain_state", st0, 1);
        check("drain_err", err0, 1);
        check("drain_nchk", nchk0, 1);
        #2;
        RST_n = 1'b0;
        #1;
        check("arst_err", err0, 0);
        check("arst_nchk", nchk0, 0);
        check("arst_ovf", ovf0, 0);
        check("arst_unf", unf0, 0);
        check("arst_done", done0, 0);
        check("arst_pass", pass0, 0);
        check("arst_state", st0, 0);
        END_SIM = 1'b0;
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);
        check("arst_stay_run", st0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
